// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared widths, FIFO word layout, raster defaults and gap-filler states.
// Revision: 1.0
`default_nettype none

package pixel_stream_pkg;

  localparam int DEF_PRECISION  = 11;
  localparam int DEF_PIXEL_SIZE = 16;
  localparam int X_LSB          = 27;
  localparam int Y_LSB          = 16;
  localparam int DEF_X_RES      = 800;
  localparam int DEF_Y_RES      = 600;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_PASS = 2'd1,
    ST_FILL = 2'd2
  } gap_state_t;

endpackage

`default_nettype wire

// File: rtl/raster_pos_counter.sv
// raster_pos_counter: expected raster position with advance/load-(1,0) and raster-order compare.
// Revision: 1.0
`default_nettype none

module raster_pos_counter
  import pixel_stream_pkg::*;
#(
  parameter int PRECISION = DEF_PRECISION,
  parameter int X_RES     = DEF_X_RES,
  parameter int Y_RES     = DEF_Y_RES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  input  logic                 load_one,
  input  logic [PRECISION-1:0] head_x,
  input  logic [PRECISION-1:0] head_y,
  output logic [PRECISION-1:0] pos_x,
  output logic [PRECISION-1:0] pos_y,
  output logic                 at_origin,
  output logic                 head_at,
  output logic                 head_ahead,
  output logic                 head_behind
);

  localparam logic [PRECISION-1:0] X_LAST = PRECISION'(X_RES - 1);
  localparam logic [PRECISION-1:0] Y_LAST = PRECISION'(Y_RES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (load_one) begin
      pos_x <= PRECISION'(1);
      pos_y <= '0;
    end else if (advance) begin
      if (pos_x == X_LAST) begin
        pos_x <= '0;
        pos_y <= (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
      end else begin
        pos_x <= pos_x + 1'b1;
      end
    end
  end

  assign at_origin   = (pos_x == '0) && (pos_y == '0);
  assign head_at     = (head_x == pos_x) && (head_y == pos_y);
  assign head_ahead  = (head_y > pos_y) || ((head_y == pos_y) && (head_x > pos_x));
  assign head_behind = !head_at && !head_ahead;

endmodule

`default_nettype wire

// File: rtl/pixel_gap_filler.sv
// pixel_gap_filler: re-times a sparse FWFT pixel stream into raster order, filling gaps.
// Optional GAP_FILLER_STATS_EN adds saturating gap/drop counters. Revision: 1.0
`default_nettype none

module pixel_gap_filler
  import pixel_stream_pkg::*;
#(
  parameter int                    PRECISION   = DEF_PRECISION,
  parameter int                    PIXEL_SIZE  = DEF_PIXEL_SIZE,
  parameter int                    X_RES       = DEF_X_RES,
  parameter int                    Y_RES       = DEF_Y_RES,
  parameter logic [PIXEL_SIZE-1:0] FILL_COLOUR = 16'h0000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*PRECISION+PIXEL_SIZE-1:0] fifo_data,
  input  logic                              fifo_empty,
  output logic                              fifo_read,
  output logic [PRECISION-1:0]              pixel_x,
  output logic [PRECISION-1:0]              pixel_y,
  output logic [PIXEL_SIZE-1:0]             pixel_data,
  output logic                              pixel_valid,
  output logic                              frame_start,
  output logic [15:0]                       gap_count,
  output logic [15:0]                       drop_count
);

  localparam bit DEF_LAYOUT = (PRECISION == DEF_PRECISION) && (PIXEL_SIZE == DEF_PIXEL_SIZE);
  localparam int XL = DEF_LAYOUT ? X_LSB : PIXEL_SIZE + PRECISION;
  localparam int YL = DEF_LAYOUT ? Y_LSB : PIXEL_SIZE;

  logic [PRECISION-1:0]  head_x, head_y, pos_x, pos_y, out_x, out_y;
  logic [PIXEL_SIZE-1:0] head_pix, out_pix;
  logic                  head_origin, in_range;
  logic                  at_origin, head_at, head_ahead, head_behind;
  logic                  pop, emit, adv, load_one;
  gap_state_t            state, state_nx;

  assign head_x      = fifo_data[XL +: PRECISION];
  assign head_y      = fifo_data[YL +: PRECISION];
  assign head_pix    = fifo_data[PIXEL_SIZE-1:0];
  assign head_origin = (head_x == '0) && (head_y == '0);
  assign in_range    = ({1'b0, head_x} < (PRECISION+1)'(X_RES)) &&
                       ({1'b0, head_y} < (PRECISION+1)'(Y_RES));

  raster_pos_counter #(
    .PRECISION (PRECISION),
    .X_RES     (X_RES),
    .Y_RES     (Y_RES)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .advance     (adv),
    .load_one    (load_one),
    .head_x      (head_x),
    .head_y      (head_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .at_origin   (at_origin),
    .head_at     (head_at),
    .head_ahead  (head_ahead),
    .head_behind (head_behind)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SYNC;
    else     state <= state_nx;
  end

  // An empty FIFO stalls everything, so fill never outruns the word that justifies it.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    emit     = 1'b0;
    adv      = 1'b0;
    load_one = 1'b0;
    out_x    = head_x;
    out_y    = head_y;
    out_pix  = head_pix;
    if (!fifo_empty) begin
      if (state == ST_SYNC) begin
        pop = 1'b1;
        if (head_origin) begin
          emit     = 1'b1;
          load_one = 1'b1;
          state_nx = ST_PASS;
        end
      end else if (!in_range) begin
        pop = 1'b1;
      end else if (head_origin && !at_origin) begin
        pop      = 1'b1;
        emit     = 1'b1;
        load_one = 1'b1;
        state_nx = ST_PASS;
      end else if (head_at) begin
        pop      = 1'b1;
        emit     = 1'b1;
        adv      = 1'b1;
        state_nx = ST_PASS;
      end else if (head_ahead) begin
        emit     = 1'b1;
        adv      = 1'b1;
        out_x    = pos_x;
        out_y    = pos_y;
        out_pix  = FILL_COLOUR;
        state_nx = ST_FILL;
      end else if (head_behind) begin
        pop = 1'b1;
      end
    end
  end

  assign fifo_read = pop & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_data  <= '0;
    end else begin
      pixel_valid <= emit;
      frame_start <= emit && (out_x == '0) && (out_y == '0);
      if (emit) begin
        pixel_x    <= out_x;
        pixel_y    <= out_y;
        pixel_data <= out_pix;
      end
    end
  end

`ifdef GAP_FILLER_STATS_EN
  logic [15:0] gap_cnt, drop_cnt;

  // A fill is an emit without a pop; a counted drop is a pop without an emit outside SYNC.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (emit && !pop && (gap_cnt != 16'hFFFF))
        gap_cnt <= gap_cnt + 16'd1;
      if (pop && !emit && (state != ST_SYNC) && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign gap_count  = gap_cnt;
  assign drop_count = drop_cnt;
`else
  assign gap_count  = '0;
  assign drop_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_gap_filler.sv
// tb_pixel_gap_filler: FWFT FIFO model, raster-index reference model and output scoreboard.
// Revision: 1.0
`default_nettype none

module tb_pixel_gap_filler;

  localparam int XR = 20;
  localparam int YR = 6;
  localparam int N  = XR * YR;
  localparam logic [15:0] FILLC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_read;
  logic [10:0] pixel_x, pixel_y;
  logic [15:0] pixel_data;
  logic        pixel_valid, frame_start;
  logic [15:0] gap_count, drop_count;

  always #5 clk = ~clk;

  pixel_gap_filler #(
    .PRECISION   (11),
    .PIXEL_SIZE  (16),
    .X_RES       (XR),
    .Y_RES       (YR),
    .FILL_COLOUR (FILLC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_read   (fifo_read),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .gap_count   (gap_count),
    .drop_count  (drop_count)
  );

  logic [37:0] fq[$];
  logic [38:0] expq[$];
  int  errors = 0;
  int  checks = 0;
  bit  synced = 0;
  int  lin = 0;
  int  m_gaps = 0;
  int  m_drops = 0;
  bit  stall = 0;
  bit  rd_seen = 0;

  task automatic refresh();
    fifo_empty = (fq.size() == 0) || stall;
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rd_seen && fq.size() > 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic exp_pix(int x, int y, logic [15:0] d);
    expq.push_back({(x == 0 && y == 0), 11'(x), 11'(y), d});
  endtask

  // Reference: expected position as a linear raster index; gaps are index differences.
  task automatic model_word(int x, int y, logic [15:0] d);
    int p;
    if (!synced) begin
      if (x == 0 && y == 0) begin
        exp_pix(0, 0, d);
        lin = 1;
        synced = 1;
      end
    end else if (x >= XR || y >= YR) begin
      m_drops++;
    end else begin
      p = y * XR + x;
      if (p == 0) begin
        exp_pix(0, 0, d);
        lin = 1;
      end else if (p >= lin) begin
        for (int k = lin; k < p; k++) begin
          exp_pix(k % XR, k / XR, FILLC);
          m_gaps++;
        end
        exp_pix(x, y, d);
        lin = (p + 1) % N;
      end else begin
        m_drops++;
      end
    end
  endtask

  task automatic push_word(int x, int y, logic [15:0] d);
    fq.push_back({11'(x), 11'(y), d});
    model_word(x, y, d);
    refresh();
  endtask

  task automatic push_idx(int p);
    push_word(p % XR, p / XR, 16'($urandom));
  endtask

  task automatic drain(string tag);
    int n;
    stall = 0;
    refresh();
    n = 0;
    while ((fq.size() != 0 || expq.size() != 0) && n < 5000) begin
      cycle();
      n++;
    end
    checks++;
    if (fq.size() != 0 || expq.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: fifo_left=%0d pixels_pending=%0d, required 0 and 0", tag, fq.size(), expq.size());
    end
  endtask

  task automatic chk_counters(string tag);
    int eg, ed;
`ifdef GAP_FILLER_STATS_EN
    eg = m_gaps;
    ed = m_drops;
`else
    eg = 0;
    ed = 0;
`endif
    @(negedge clk);
    checks++;
    if (int'(gap_count) != eg) begin
      errors++;
      $display("FAIL gap_count_%s: got %0d, required %0d", tag, gap_count, eg);
    end
    checks++;
    if (int'(drop_count) != ed) begin
      errors++;
      $display("FAIL drop_count_%s: got %0d, required %0d", tag, drop_count, ed);
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    fq.delete();
    expq.delete();
    synced  = 0;
    lin     = 0;
    m_gaps  = 0;
    m_drops = 0;
    stall   = 0;
    refresh();
    @(negedge clk);
    checks++;
    if ({pixel_valid, frame_start, pixel_x, pixel_y, pixel_data} != '0) begin
      errors++;
      $display("FAIL reset_outputs_%s: got valid=%b fs=%b x=%0d y=%0d d=%h, required all 0",
               tag, pixel_valid, frame_start, pixel_x, pixel_y, pixel_data);
    end
    checks++;
    if (gap_count != 16'd0 || drop_count != 16'd0) begin
      errors++;
      $display("FAIL reset_counters_%s: got gap=%0d drop=%0d, required 0 and 0", tag, gap_count, drop_count);
    end
    cycle();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    logic [38:0] e, got;
    rd_seen = fifo_read;
    if (fifo_read) begin
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL read_when_empty: got fifo_read=1 with fifo_empty=1, required 0");
      end
    end
    if (pixel_valid) begin
      checks++;
      got = {frame_start, pixel_x, pixel_y, pixel_data};
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel: got fs=%b x=%0d y=%0d d=%h, required no pixel",
                 frame_start, pixel_x, pixel_y, pixel_data);
      end else begin
        e = expq.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pixel: got fs=%b x=%0d y=%0d d=%h, required fs=%b x=%0d y=%0d d=%h",
                   got[38], got[37:27], got[26:16], got[15:0], e[38], e[37:27], e[26:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p;
    do_reset("initial");

    // SYNC discards, then two contiguous frames across the wrap
    push_word(5, 3, 16'h1111);
    push_word(9, 9, 16'h2222);
    for (int i = 0; i < 2 * N; i++) push_idx(i % N);
    drain("frames");
    chk_counters("frames");

    // gap of three ahead of expected (10,2)
    for (int i = 0; i < 2 * XR + 10; i++) push_idx(i);
    push_word(13, 2, 16'hF800);
    drain("gap3");
    chk_counters("gap3");

    // behind and out-of-range at expected (0,5)
    for (int i = 2 * XR + 14; i < 5 * XR; i++) push_idx(i);
    push_word(XR - 1, 4, 16'hABCD);
    push_word(XR + 5, 5, 16'hBCDE);
    drain("drops");
    chk_counters("drops");

    // frame restart from the middle of a frame
    push_word(0, 0, 16'h0F0F);
    for (int i = 1; i < 3 * XR + 10; i++) push_idx(i);
    push_word(0, 0, 16'h5A5A);
    push_idx(1);
    drain("restart");
    chk_counters("restart");

    // randomized traffic with FIFO stalls
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      if (!synced) begin
        if (r < 50) push_word(0, 0, 16'($urandom));
        else push_word($urandom_range(0, XR - 1), $urandom_range(0, YR - 1), 16'($urandom));
      end else if (r < 65) begin
        push_idx(lin);
      end else if (r < 80) begin
        p = lin + 1 + $urandom_range(0, 4);
        push_idx((p >= N) ? 0 : p);
      end else if (r < 87) begin
        push_idx((lin > 0) ? $urandom_range(0, lin - 1) : 0);
      end else if (r < 92) begin
        push_word(XR + $urandom_range(0, 30), $urandom_range(0, YR + 3), 16'($urandom));
      end else if (r < 95) begin
        push_word(0, 0, 16'($urandom));
      end else begin
        push_word($urandom_range(0, XR - 1), $urandom_range(0, YR - 1), 16'($urandom));
      end
      for (int c = $urandom_range(0, 2); c > 0; c--) begin
        stall = ($urandom_range(0, 7) == 0);
        cycle();
      end
      if (fq.size() > 40) drain("random_burst");
    end
    drain("random");
    chk_counters("random");

    // reset in the middle of a 50-pixel fill
    do_reset("pre_fill");
    for (int i = 0; i < 6; i++) push_idx(i);
    push_idx(56);
    for (int i = 0; i < 15; i++) cycle();
    do_reset("mid_fill");
    push_word(0, 0, 16'h1234);
    push_idx(1);
    push_idx(2);
    drain("after_reset");
    chk_counters("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_gap_filler.md
PIXEL_GAP_FILLER -- requirements
Module: pixel_gap_filler

Interface
REQ-001 SHALL have parameter PRECISION, default 11, coordinate width.
REQ-002 SHALL have parameter PIXEL_SIZE, default 16, RGB565 pixel width.
REQ-003 SHALL have parameter X_RES, default 800, active pixels per line.
REQ-004 SHALL have parameter Y_RES, default 600, active lines per frame.
REQ-005 SHALL have parameter FILL_COLOUR, default 16'h0000, colour of inserted pixels.
REQ-006 SHALL have port clk, in, 1: single clock (clk80 domain); one clock, reset synchronous, active-high.
REQ-007 SHALL have port rst, in, 1: synchronous active-high reset.
REQ-008 SHALL have port fifo_data, in, 2*PRECISION+PIXEL_SIZE (38): x[37:27], y[26:16], pixel[15:0].
REQ-009 SHALL have port fifo_empty, in, 1: ADC FIFO empty flag.
REQ-010 SHALL have port fifo_read, out, 1: pop strobe; FIFO is first-word-fall-through.
REQ-011 SHALL have port pixel_x, out, PRECISION: output x.
REQ-012 SHALL have port pixel_y, out, PRECISION: output y.
REQ-013 SHALL have port pixel_data, out, PIXEL_SIZE: output colour.
REQ-014 SHALL have port pixel_valid, out, 1: one-cycle strobe per output pixel.
REQ-015 SHALL have port frame_start, out, 1: pulses with the output pixel at (0,0).
REQ-016 SHALL have port gap_count, out, 16: pixels inserted since reset, saturating.
REQ-017 SHALL have port drop_count, out, 16: words discarded since reset, saturating.

Function
REQ-018 SHALL track an expected position (ex,ey) in raster order; ex wraps X_RES-1->0 with ey+1; ey wraps Y_RES-1->0.
REQ-019 SHALL implement states SYNC, PASS, FILL.
REQ-020 SYNC: pop and drop every word except one at (0,0); on (0,0) emit it, set expected (1,0), go PASS; drops in SYNC not counted.
REQ-021 PASS, word at expected: pop, emit word, advance expected.
REQ-022 PASS, word ahead of expected in raster order: do not pop, emit FILL_COLOUR at expected, advance, enter FILL.
REQ-023 FILL: emit one fill pixel per cycle at expected until expected equals head word coordinates, then handle as REQ-021 in the same cycle and return to PASS.
REQ-024 Word at (0,0) while expected is not (0,0): frame restart; no fill of the remaining frame; emit it, expected (1,0), PASS.
REQ-025 Word behind expected (not (0,0)) or with x>=X_RES or y>=Y_RES: pop, discard, drop_count+1, no output that cycle.
REQ-026 fifo_read SHALL be combinational, only asserted with fifo_empty low; outputs registered; latency FIFO head to pixel_valid = 1 cycle.
REQ-027 fifo_empty high in PASS or FILL: no output, no pop, state held; fill never runs ahead of an unseen word.
REQ-028 Throughput: at most one output pixel per clk; gap_count and drop_count saturate at 16'hFFFF.

Reset
REQ-029 rst SHALL force state SYNC, expected (0,0), fifo_read 0, pixel_valid 0, frame_start 0, pixel_x/y/data 0, both counters 0; rst mid-fill abandons fill at once.

Configuration
REQ-030 With GAP_FILLER_STATS_EN defined, gap_count and drop_count SHALL behave as REQ-016/017/025; undefined, both SHALL be constant 0 and their counter registers SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package pixel_stream_pkg SHALL hold PRECISION, PIXEL_SIZE, FIFO word field offsets (X_LSB=27, Y_LSB=16), X_RES/Y_RES defaults, and the SYNC/PASS/FILL state enum.
REQ-032 Expected-position counter SHALL be sub-module raster_pos_counter (advance, load-(1,0), compare-ahead/behind outputs).

Verification
REQ-033 Reset, then stream (0,0)..(799,599) contiguous -> 480000 pixel_valid, identical data, frame_start once, counters 0.
REQ-034 From SYNC feed (5,3),(9,9) then (0,0) -> first two dropped uncounted; output begins at (0,0).
REQ-035 PASS, expected (10,2), head (13,2) colour 16'hF800 -> fills at (10,2),(11,2),(12,2) colour 0, then (13,2)=F800; gap_count=3.
REQ-036 Expected (0,5), head (799,4) -> popped, no output, drop_count=1; head (900,5) -> dropped, drop_count=2.
REQ-037 Expected (400,300), head (0,0) -> emitted next cycle with frame_start, no fill, expected (1,0).
REQ-038 rst asserted during a 50-pixel fill -> next cycle pixel_valid 0, state SYNC; without GAP_FILLER_STATS_EN counters read 0 throughout.
